// File: rtl/fpu_issue_pkg.sv
// Shared FPU definitions: opcode constants, issue FSM state encoding and
// response error codes.
package fpu_issue_pkg;

  // Floating-point opcodes handled by the FPU (JVM encodings)
  localparam logic [7:0] OP_FADD  = 8'h62;
  localparam logic [7:0] OP_DADD  = 8'h63;
  localparam logic [7:0] OP_FSUB  = 8'h66;
  localparam logic [7:0] OP_DSUB  = 8'h67;
  localparam logic [7:0] OP_FMUL  = 8'h6A;
  localparam logic [7:0] OP_DMUL  = 8'h6B;
  localparam logic [7:0] OP_FDIV  = 8'h6E;
  localparam logic [7:0] OP_DDIV  = 8'h6F;
  localparam logic [7:0] OP_FREM  = 8'h72;
  localparam logic [7:0] OP_DREM  = 8'h73;
  localparam logic [7:0] OP_I2F   = 8'h86;
  localparam logic [7:0] OP_I2D   = 8'h87;
  localparam logic [7:0] OP_L2F   = 8'h89;
  localparam logic [7:0] OP_L2D   = 8'h8A;
  localparam logic [7:0] OP_F2I   = 8'h8B;
  localparam logic [7:0] OP_F2L   = 8'h8C;
  localparam logic [7:0] OP_F2D   = 8'h8D;
  localparam logic [7:0] OP_D2I   = 8'h8E;
  localparam logic [7:0] OP_D2L   = 8'h8F;
  localparam logic [7:0] OP_D2F   = 8'h90;
  localparam logic [7:0] OP_FCMPL = 8'h95;
  localparam logic [7:0] OP_FCMPG = 8'h96;
  localparam logic [7:0] OP_DCMPL = 8'h97;
  localparam logic [7:0] OP_DCMPG = 8'h98;

  // Issue FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPR1 = 3'd1,
    ST_OPR2 = 3'd2,
    ST_EXEC = 3'd3,
    ST_OUT2 = 3'd4
  } fpu_state_e;

  // Response error codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_BUSY    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/fpu_op_class.sv
// Opcode classifier: legal FP opcode, two operand beats, two result words.
module fpu_op_class
  import fpu_issue_pkg::*;
(
  input  logic [7:0] op,
  output logic       op_valid,
  output logic       two_beat,
  output logic       two_word
);

  // Decode the opcode into its operand/result shape
  always_comb begin
    op_valid = 1'b0;
    two_beat = 1'b0;
    two_word = 1'b0;
    case (op)
      OP_DADD, OP_DSUB, OP_DMUL, OP_DDIV, OP_DREM: begin
        op_valid = 1'b1;
        two_beat = 1'b1;
        two_word = 1'b1;
      end
      OP_DCMPL, OP_DCMPG: begin
        op_valid = 1'b1;
        two_beat = 1'b1;
      end
      OP_D2L, OP_L2D, OP_F2D, OP_F2L, OP_I2D: begin
        op_valid = 1'b1;
        two_word = 1'b1;
      end
      OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FREM, OP_I2F, OP_L2F,
      OP_F2I, OP_D2I, OP_D2F, OP_FCMPL, OP_FCMPG: begin
        op_valid = 1'b1;
      end
      default: begin
        op_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fpu_issue.sv
// FPU issue unit: accepts an FP request from the IU, streams its operand
// words to the FPU, waits for the result and returns it with a status code.
//
// Handshake: a request transfers on a rising pj_clk edge where req_valid
// and req_ready are both high; req_op/req_w* must be stable while
// req_valid is high. req_ready is high only in IDLE with no hold or kill.
// rsp_valid is a one-cycle pulse with no back-pressure.
module fpu_issue
  import fpu_issue_pkg::*;
#(
  parameter int MAX_BSY_LENGTH = 64
) (
  input  logic        pj_clk,
  input  logic        pj_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_w0,
  input  logic [31:0] req_w1,
  input  logic [31:0] req_w2,
  input  logic [31:0] req_w3,
  input  logic        iu_hold,
  input  logic        iu_kill,
  output logic [7:0]  fpop,
  output logic        fpop_valid,
  output logic [31:0] fpain,
  output logic [31:0] fpbin,
  output logic        fphold,
  output logic        fpkill,
  input  logic [31:0] fpout,
  input  logic        fpbusyn,
  output logic        rsp_valid,
  output logic [31:0] rsp_data0,
  output logic [31:0] rsp_data1,
  output logic [1:0]  rsp_err,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(MAX_BSY_LENGTH + 1);
  localparam logic [CW-1:0] BSY_LAST = CW'(MAX_BSY_LENGTH - 1);

  fpu_state_e  state_q, state_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic        two_beat_q, two_word_q, first_exec_q;
  logic [1:0]  err_q;
  logic [CW-1:0] bsy_cnt_q;

  logic cls_valid, cls_two_beat, cls_two_word;
  logic accept, busy_viol_opr2, busy_viol_exec, exec_done, out2_done, timeout;
  logic [1:0] err_cur;

  fpu_op_class u_op_class (
    .op       (req_op),
    .op_valid (cls_valid),
    .two_beat (cls_two_beat),
    .two_word (cls_two_word)
  );

  assign fphold    = iu_hold;
  assign fpkill    = iu_kill;
  assign dbg_state = state_q;

  // Event decode shared by the FSM and the datapath; kill masks everything
  always_comb begin
    accept         = (state_q == ST_IDLE) && req_valid && req_ready;
    busy_viol_opr2 = (state_q == ST_OPR2) && !iu_kill && !iu_hold && fpbusyn;
    busy_viol_exec = (state_q == ST_EXEC) && !iu_kill && first_exec_q &&
                     !two_beat_q && fpbusyn;
    exec_done      = (state_q == ST_EXEC) && !iu_kill && !iu_hold && fpbusyn;
    timeout        = (state_q == ST_EXEC) && !iu_kill && !fpbusyn &&
                     (bsy_cnt_q == BSY_LAST);
    out2_done      = (state_q == ST_OUT2) && !iu_kill && !iu_hold;
    err_cur        = busy_viol_exec ? ERR_BUSY : err_q;
  end

  // State register
  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && cls_valid) state_d = ST_OPR1;
      ST_OPR1: begin
        if (iu_kill)       state_d = ST_IDLE;
        else if (!iu_hold) state_d = two_beat_q ? ST_OPR2 : ST_EXEC;
      end
      ST_OPR2: begin
        if (iu_kill)       state_d = ST_IDLE;
        else if (!iu_hold) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (iu_kill || timeout) state_d = ST_IDLE;
        else if (exec_done)     state_d = two_word_q ? ST_OUT2 : ST_IDLE;
      end
      ST_OUT2: begin
        if (iu_kill || !iu_hold) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: request acceptance, FPU opcode and operand buses
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !iu_hold && !iu_kill;
    fpop_valid = (state_q == ST_IDLE) && req_valid && req_ready && cls_valid;
    fpop       = fpop_valid ? req_op : 8'h00;
    fpain      = 32'h0;
    fpbin      = 32'h0;
    case (state_q)
      ST_OPR1: begin fpain = w0_q; fpbin = w1_q; end
      ST_OPR2: begin fpain = w2_q; fpbin = w3_q; end
      default: begin fpain = 32'h0; fpbin = 32'h0; end
    endcase
  end

  // Operand capture, protocol/timeout tracking and result registers
  always_ff @(posedge pj_clk or posedge pj_reset) begin
    if (pj_reset) begin
      w0_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      two_beat_q   <= 1'b0;
      two_word_q   <= 1'b0;
      first_exec_q <= 1'b0;
      err_q        <= ERR_OK;
      bsy_cnt_q    <= '0;
      rsp_valid    <= 1'b0;
      rsp_data0    <= '0;
      rsp_data1    <= '0;
      rsp_err      <= ERR_OK;
    end else begin
      rsp_valid    <= 1'b0;
      first_exec_q <= (state_d == ST_EXEC) && (state_q != ST_EXEC);
      if (accept) begin
        if (cls_valid) begin
          w0_q       <= req_w0;
          w1_q       <= req_w1;
          w2_q       <= req_w2;
          w3_q       <= req_w3;
          two_beat_q <= cls_two_beat;
          two_word_q <= cls_two_word;
          err_q      <= ERR_OK;
          bsy_cnt_q  <= '0;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= ERR_BAD_OP;
        end
      end
      if (busy_viol_opr2 || busy_viol_exec) err_q <= ERR_BUSY;
      if ((state_q == ST_EXEC) && !iu_kill && !fpbusyn) bsy_cnt_q <= bsy_cnt_q + CW'(1);
      if (exec_done) begin
        rsp_data0 <= fpout;
        if (!two_word_q) begin
          rsp_data1 <= 32'h0;
          rsp_valid <= 1'b1;
          rsp_err   <= err_cur;
        end
      end
      if (out2_done) begin
        rsp_data1 <= fpout;
        rsp_valid <= 1'b1;
        rsp_err   <= err_q;
      end
      if (timeout) begin
        rsp_valid <= 1'b1;
        rsp_err   <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: directed scenarios followed by randomized operations,
// each checked cycle by cycle against a schedule derived from the opcode
// tables and the issue rules.
module tb_fpu_issue;

  localparam int MAXB = 64;

  logic        pj_clk = 1'b0;
  logic        pj_reset;
  logic        req_valid, req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_w0, req_w1, req_w2, req_w3;
  logic        iu_hold, iu_kill;
  logic [7:0]  fpop;
  logic        fpop_valid;
  logic [31:0] fpain, fpbin;
  logic        fphold, fpkill;
  logic [31:0] fpout;
  logic        fpbusyn;
  logic        rsp_valid;
  logic [31:0] rsp_data0, rsp_data1;
  logic [1:0]  rsp_err;
  logic [2:0]  dbg_state;

  fpu_issue #(.MAX_BSY_LENGTH(MAXB)) dut (
    .pj_clk(pj_clk), .pj_reset(pj_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_w0(req_w0), .req_w1(req_w1), .req_w2(req_w2), .req_w3(req_w3),
    .iu_hold(iu_hold), .iu_kill(iu_kill),
    .fpop(fpop), .fpop_valid(fpop_valid), .fpain(fpain), .fpbin(fpbin),
    .fphold(fphold), .fpkill(fpkill),
    .fpout(fpout), .fpbusyn(fpbusyn),
    .rsp_valid(rsp_valid), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 pj_clk = ~pj_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model of the held result words (survive until the next capture)
  logic [31:0] m_d0, m_d1;

  // Scoreboard: expected response as err, data0, data1
  logic [31:0] exp_q[$];

  // One planned cycle after acceptance: inputs and expected operand buses
  typedef struct {
    logic        hold;
    logic        kill;
    logic        busyn;
    logic [31:0] fout;
    logic [31:0] ea;
    logic [31:0] eb;
  } cyc_t;
  cyc_t sched[$];

  logic [7:0] valid_ops [24] = '{8'h62, 8'h63, 8'h66, 8'h67, 8'h6A, 8'h6B,
                                 8'h6E, 8'h6F, 8'h72, 8'h73, 8'h86, 8'h87,
                                 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E,
                                 8'h8F, 8'h90, 8'h95, 8'h96, 8'h97, 8'h98};

  function automatic bit is_valid(input logic [7:0] op);
    foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_two_beat(input logic [7:0] op);
    return op inside {8'h98, 8'h97, 8'h63, 8'h67, 8'h6B, 8'h6F, 8'h73};
  endfunction

  function automatic bit is_two_word(input logic [7:0] op);
    return op inside {8'h63, 8'h67, 8'h6B, 8'h6F, 8'h73,
                      8'h8F, 8'h8A, 8'h8D, 8'h8C, 8'h87};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pj_clk);
    #1;
  endtask

  task automatic push_cyc(input logic hold, input logic busyn, input logic [31:0] fout,
                          input logic [31:0] ea, input logic [31:0] eb);
    cyc_t c;
    c.hold = hold; c.kill = 1'b0; c.busyn = busyn; c.fout = fout; c.ea = ea; c.eb = eb;
    sched.push_back(c);
  endtask

  // Issue one request starting in the current (IDLE) cycle and follow it to
  // its response cycle. h1: hold cycles in OPR1, b: fpbusyn-low EXEC cycles
  // (>= MAXB means timeout), opr2_busy: fpbusyn high in OPR2, h2: hold cycles
  // with fpbusyn high, h3: hold cycles in OUT2, kill_at: planned cycle to kill.
  task automatic do_op(input logic [7:0] op, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input logic [31:0] r0, input logic [31:0] r1,
                       input int h1, input int b, input bit opr2_busy,
                       input int h2, input int h3, input int kill_at);
    bit valid, tb2, tw2, killed, timed_out;
    logic [31:0] e_err, e_d0, e_d1;
    valid = is_valid(op); tb2 = is_two_beat(op); tw2 = is_two_word(op);
    killed = 1'b0; timed_out = 1'b0;

    req_valid = 1'b1; req_op = op;
    req_w0 = w0; req_w1 = w1; req_w2 = w2; req_w3 = w3;
    iu_hold = 1'b0; iu_kill = 1'b0;
    fpbusyn = 1'($urandom_range(0, 1)); fpout = $urandom;
    #1;
    check("req_ready_idle", req_ready, 1);
    check("fpop_valid_acc", fpop_valid, valid);
    check("fpop_acc", fpop, valid ? op : 8'h00);
    tick();
    req_valid = 1'b0;

    if (!valid) begin
      #1;
      exp_q.push_back(32'd1); exp_q.push_back(m_d0); exp_q.push_back(m_d1);
    end else begin
      sched.delete();
      for (int i = 0; i < h1; i++) push_cyc(1'b1, 1'($urandom_range(0, 1)), $urandom, w0, w1);
      push_cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, w0, w1);
      if (tb2) push_cyc(1'b0, opr2_busy, $urandom, w2, w3);
      e_err = (tb2 ? opr2_busy : (b == 0)) ? 32'd2 : 32'd0;
      if (b >= MAXB) begin
        for (int i = 0; i < MAXB; i++) push_cyc(1'b0, 1'b0, $urandom, 0, 0);
        timed_out = 1'b1;
        e_err = 32'd3;
      end else begin
        for (int i = 0; i < b; i++) push_cyc(1'b0, 1'b0, $urandom, 0, 0);
        for (int i = 0; i < h2; i++) push_cyc(1'b1, 1'b1, $urandom, 0, 0);
        push_cyc(1'b0, 1'b1, r0, 0, 0);
        if (tw2) begin
          for (int i = 0; i < h3; i++) push_cyc(1'b1, 1'($urandom_range(0, 1)), $urandom, 0, 0);
          push_cyc(1'b0, 1'($urandom_range(0, 1)), r1, 0, 0);
        end
      end
      if (kill_at >= 0 && kill_at < sched.size()) begin
        sched[kill_at].kill = 1'b1;
        while (sched.size() > kill_at + 1) void'(sched.pop_back());
        killed = 1'b1;
      end

      foreach (sched[i]) begin
        iu_hold = sched[i].hold; iu_kill = sched[i].kill;
        fpbusyn = sched[i].busyn; fpout = sched[i].fout;
        req_valid = 1'($urandom_range(0, 1)); req_op = 8'($urandom_range(0, 255));
        #1;
        check("fpain", fpain, sched[i].ea);
        check("fpbin", fpbin, sched[i].eb);
        check("rsp_valid_busy", rsp_valid, 0);
        check("req_ready_busy", req_ready, 0);
        check("fpop_valid_busy", fpop_valid, 0);
        check("fphold", fphold, sched[i].hold);
        check("fpkill", fpkill, sched[i].kill);
        tick();
      end
      req_valid = 1'b0; iu_hold = 1'b0; iu_kill = 1'b0;
      #1;
      if (killed) begin
        check("rsp_valid_kill", rsp_valid, 0);
      end else begin
        if (!timed_out) begin
          m_d0 = r0;
          m_d1 = tw2 ? r1 : 32'h0;
        end
        exp_q.push_back(e_err); exp_q.push_back(m_d0); exp_q.push_back(m_d1);
      end
    end

    if (exp_q.size() != 0) begin
      e_err = exp_q.pop_front(); e_d0 = exp_q.pop_front(); e_d1 = exp_q.pop_front();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, e_err);
      check("rsp_data0", rsp_data0, e_d0);
      check("rsp_data1", rsp_data1, e_d1);
    end
    check("state_idle", dbg_state, 0);
  endtask

  initial begin
    int b, kill_at;
    logic [7:0] op;

    // Reset
    pj_reset = 1'b1; req_valid = 1'b0; req_op = 8'h00;
    req_w0 = 0; req_w1 = 0; req_w2 = 0; req_w3 = 0;
    iu_hold = 1'b0; iu_kill = 1'b0; fpout = 0; fpbusyn = 1'b1;
    repeat (2) @(posedge pj_clk);
    #1;
    check("rst_state", dbg_state, 0);
    check("rst_fpop_valid", fpop_valid, 0);
    check("rst_fpop", fpop, 0);
    check("rst_fpain", fpain, 0);
    check("rst_fpbin", fpbin, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data0", rsp_data0, 0);
    check("rst_rsp_data1", rsp_data1, 0);
    check("rst_rsp_err", rsp_err, 0);
    pj_reset = 1'b0;
    m_d0 = 32'h0; m_d1 = 32'h0;
    tick();
    check("req_ready_after_rst", req_ready, 1);

    // FADD 1.0 + 2.0, fpbusyn low 3 cycles
    do_op(8'h62, 32'h3F800000, 32'h40000000, 32'h0, 32'h0, 32'h40400000, 32'h0,
          0, 3, 1'b0, 0, 0, -1);
    // DADD, four operand words, two result words
    do_op(8'h63, 32'h3FF00000, 32'h0, 32'h40000000, 32'h0, 32'h40080000, 32'h0,
          0, 2, 1'b0, 0, 0, -1);
    // FMUL with two hold cycles in OPR1 and two at fpbusyn high
    do_op(8'h6A, 32'h40000000, 32'h40400000, 32'h0, 32'h0, 32'h40C00000, 32'h0,
          2, 1, 1'b0, 2, 0, -1);
    // DDIV killed in its first EXEC cycle, then an immediate new request
    do_op(8'h6F, 32'h1, 32'h2, 32'h3, 32'h4, 32'hDEAD0000, 32'hBEEF0000,
          0, 3, 1'b0, 0, 0, 2);
    do_op(8'h8D, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3FF00000, 32'h0,
          0, 1, 1'b0, 0, 1, -1);
    // Illegal opcode
    do_op(8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 0, 0, -1);
    // F2I with fpbusyn high in the first EXEC cycle, then a timeout
    do_op(8'h8B, 32'h40490FDB, 32'h0, 32'h0, 32'h0, 32'h00000003, 32'h0,
          0, 0, 1'b0, 0, 0, -1);
    do_op(8'h8B, 32'h40490FDB, 32'h0, 32'h0, 32'h0, 32'h00000003, 32'h0,
          0, MAXB, 1'b0, 0, 0, -1);
    // DCMPL with fpbusyn high in OPR2
    do_op(8'h97, 32'h5, 32'h6, 32'h7, 32'h8, 32'hFFFFFFFF, 32'h0,
          1, 1, 1'b1, 0, 0, -1);

    // Reset in the middle of an FADD: no response, results cleared
    req_valid = 1'b1; req_op = 8'h62; req_w0 = 32'h11; req_w1 = 32'h22;
    tick();
    req_valid = 1'b0; fpbusyn = 1'b0;
    tick();
    tick();
    pj_reset = 1'b1;
    #1;
    check("midrst_state", dbg_state, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    tick();
    pj_reset = 1'b0;
    m_d0 = 32'h0; m_d1 = 32'h0;
    tick();
    check("midrst_rsp_valid_after", rsp_valid, 0);
    check("midrst_rsp_data0", rsp_data0, 0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 8'($urandom_range(0, 255));
        if (is_valid(op)) op = 8'hFF;
      end else begin
        op = valid_ops[$urandom_range(0, 23)];
      end
      b = ($urandom_range(0, 15) == 0) ? int'($urandom_range(MAXB, MAXB + 3))
                                        : int'($urandom_range(0, 4));
      kill_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_op(op, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            int'($urandom_range(0, 2)), b, ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), kill_at);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
